// File: rtl/jtag_shift_master.sv
// jtag_shift_master: on-board JTAG master producing TCK/TMS/TDI scan sequences
// and capturing TDO. It accepts DR-scan, IR-scan and TAP-reset commands over a
// valid/ready handshake and returns the captured TDO bits as a response.
//
// Ports:
//   CLK, RST_N           system clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op               00 DR scan, 01 IR scan, 1x TAP reset
//   cmd_len              scan length minus one
//   cmd_data             TDI bits, LSB shifted first
//   rsp_valid/rsp_data   one-cycle completion pulse with captured TDO bits
//   busy                 a pin sequence (including post-reset TLR) is running
//   JB_TCK/JB_TMS/JB_TDI registered JTAG pin outputs
//   JB_TDO               asynchronous JTAG data return
module jtag_shift_master #(
    parameter int DIV = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        JB_TCK,
    output logic        JB_TMS,
    output logic        JB_TDI,
    input  logic        JB_TDO
);

    typedef enum logic [1:0] {
        S_AUTO_TLR,
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [8:0] PH_PRE = 9'(DIV - 1);
    localparam logic [8:0] PH_END = 9'(2 * DIV - 1);

    state_t      r_state;
    logic        r_start;
    logic [8:0]  r_ph;
    logic [5:0]  r_per;
    logic [1:0]  r_op;
    logic [4:0]  r_len;
    logic [31:0] r_data;
    logic [31:0] r_cap;
    logic        r_shift;
    logic [4:0]  r_bit;
    logic        r_tdo_s1;
    logic        r_tdo_s2;
    logic        r_tck;
    logic        r_tms;
    logic        r_tdi;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;

    logic        w_idle;
    logic        w_run;
    logic        w_accept;
    logic        w_end_per;
    logic        w_fin;
    logic        w_start;
    logic [1:0]  w_src_op;
    logic [4:0]  w_src_len;
    logic [31:0] w_src_data;
    logic [5:0]  w_np;
    logic [5:0]  w_n;
    logic [5:0]  w_pre;
    logic [5:0]  w_off;
    logic [5:0]  w_last;
    logic        w_tms;
    logic        w_shift;
    logic [4:0]  w_k;

    assign w_idle   = (r_state == S_IDLE);
    assign w_run    = (r_state == S_AUTO_TLR) || (r_state == S_RUN);
    assign w_accept = w_idle && cmd_valid;

    // Period timing: a period ends on the last phase; the final period of
    // the sequence finishes the command instead of starting another one.
    assign w_end_per = w_run && !r_start && (r_ph == PH_END);
    assign w_last    = r_op[1] ? 6'd5
                     : (r_op[0] ? 6'd4 : 6'd3) + 6'(r_len) + 6'd2;
    assign w_fin     = w_end_per && (r_per == w_last);
    assign w_start   = w_accept || (w_run && r_start) || (w_end_per && !w_fin);

    // The period about to start is decoded from the live command when
    // accepting, otherwise from the latched copy.
    assign w_src_op   = w_idle ? cmd_op   : r_op;
    assign w_src_len  = w_idle ? cmd_len  : r_len;
    assign w_src_data = w_idle ? cmd_data : r_data;
    assign w_np       = (w_idle || r_start) ? 6'd0 : r_per + 6'd1;
    assign w_n        = 6'(w_src_len) + 6'd1;
    assign w_pre      = w_src_op[0] ? 6'd4 : 6'd3;
    assign w_off      = w_np - w_pre;

    always_comb begin
        w_tms   = 1'b0;
        w_shift = 1'b0;
        w_k     = 5'd0;
        if (w_src_op[1]) begin
            w_tms = (w_np < 6'd5);
        end else if (w_np < w_pre) begin
            // IR walks 1,1,0,0 and DR walks 1,0,0 into the shift state.
            w_tms = w_src_op[0] ? (w_np < 6'd2) : (w_np == 6'd0);
        end else if (w_off < w_n) begin
            w_shift = 1'b1;
            w_k     = w_off[4:0];
            w_tms   = (w_off == w_n - 6'd1);
        end else begin
            w_tms = (w_off == w_n);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_AUTO_TLR;
            r_start     <= 1'b1;
            r_ph        <= '0;
            r_per       <= '0;
            r_op        <= 2'b10;
            r_len       <= '0;
            r_data      <= '0;
            r_cap       <= '0;
            r_shift     <= 1'b0;
            r_bit       <= '0;
            r_tdo_s1    <= 1'b0;
            r_tdo_s2    <= 1'b0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_tdo_s1    <= JB_TDO;
            r_tdo_s2    <= r_tdo_s1;
            r_rsp_valid <= 1'b0;

            if (w_start) begin
                r_start <= 1'b0;
                r_ph    <= '0;
                r_per   <= w_np;
                r_tck   <= 1'b0;
                r_tms   <= w_tms;
                r_tdi   <= w_shift & w_src_data[w_k];
                r_shift <= w_shift;
                r_bit   <= w_k;
            end else if (w_fin) begin
                r_tck   <= 1'b0;
                r_tdi   <= 1'b0;
                r_shift <= 1'b0;
            end else if (w_run && !r_start) begin
                r_ph <= r_ph + 9'd1;
                if (r_ph == PH_PRE) begin
                    r_tck <= 1'b1;
                    if (r_shift) begin
                        r_cap[r_bit] <= r_tdo_s2;
                    end
                end
            end

            if (w_accept) begin
                r_op   <= cmd_op;
                r_len  <= cmd_len;
                r_data <= cmd_data;
                r_cap  <= '0;
            end

            unique case (r_state)
                S_AUTO_TLR: begin
                    if (w_fin) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_fin) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_op[1] ? 32'd0 : r_cap;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = w_idle;
    assign busy      = w_run;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign JB_TCK    = r_tck;
    assign JB_TMS    = r_tms;
    assign JB_TDI    = r_tdi;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Testbench for jtag_shift_master: scoreboards expected TMS/TDI per TCK period
// and expected responses/latencies; the target is a 1-bit TDI-to-TDO loop.
module tb_jtag_shift_master;

    localparam int DIV = 5;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        JB_TCK;
    logic        JB_TMS;
    logic        JB_TDI;
    logic        JB_TDO = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [1:0]  q_pin[$];
    logic [31:0] q_rsp[$];
    int          q_lat[$];

    logic        m_prev_tck = 1'b0;
    logic [1:0]  m_e;
    logic [31:0] m_r;
    int          m_l;
    logic        r_b = 1'b0;

    jtag_shift_master #(.DIV(DIV)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_len(cmd_len),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .JB_TCK(JB_TCK),
        .JB_TMS(JB_TMS),
        .JB_TDI(JB_TDI),
        .JB_TDO(JB_TDO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Target: TDI captured on rising TCK, presented on TDO at falling TCK.
    always @(posedge JB_TCK) r_b <= JB_TDI;
    always @(negedge JB_TCK) JB_TDO <= r_b;

    always @(negedge CLK) begin
        if (JB_TCK === 1'b1 && m_prev_tck === 1'b0) begin
            n_checks++;
            if (q_pin.size() == 0) begin
                n_fail++;
                $display("FAIL period_extra: tms=%b tdi=%b, required no period",
                         JB_TMS, JB_TDI);
            end else begin
                m_e = q_pin.pop_front();
                if ({JB_TMS, JB_TDI} !== m_e) begin
                    n_fail++;
                    $display("FAIL period_pins: tms/tdi=%b%b, required %b%b",
                             JB_TMS, JB_TDI, m_e[1], m_e[0]);
                end
            end
        end
        m_prev_tck = JB_TCK;
        if (rsp_valid !== 1'b0) begin
            n_checks++;
            if (q_rsp.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_extra: rsp_valid=%b data=%h, required none",
                         rsp_valid, rsp_data);
            end else begin
                m_r = q_rsp.pop_front();
                m_l = q_lat.pop_front();
                if (rsp_data !== m_r) begin
                    n_fail++;
                    $display("FAIL rsp_data: got %h, required %h", rsp_data, m_r);
                end
                n_checks++;
                if (cyc != m_l) begin
                    n_fail++;
                    $display("FAIL rsp_latency: cycle %0d, required %0d", cyc, m_l);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [1:0] op, input logic [4:0] len,
                            input logic [31:0] data, input int acc);
        int n;
        int p;
        logic [31:0] mask;
        logic [31:0] r;
        n = int'(len) + 1;
        r = 32'd0;
        if (op[1]) begin
            repeat (5) q_pin.push_back(2'b10);
            q_pin.push_back(2'b00);
            p = 6;
        end else begin
            q_pin.push_back(2'b10);
            if (op[0]) q_pin.push_back(2'b10);
            q_pin.push_back(2'b00);
            q_pin.push_back(2'b00);
            for (int k = 0; k < n; k++)
                q_pin.push_back({logic'(k == n - 1), data[k]});
            q_pin.push_back(2'b10);
            q_pin.push_back(2'b00);
            p = n + (op[0] ? 6 : 5);
            mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
            r = (data << 1) & mask;
        end
        if (acc >= 0) begin
            q_rsp.push_back(r);
            q_lat.push_back(acc + p * 2 * DIV + 1);
        end
    endtask

    task automatic wait_ready(input int budget);
        int i;
        i = 0;
        @(negedge CLK);
        while (cmd_ready !== 1'b1 && i < budget) begin
            @(negedge CLK);
            i++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: ready=%b after %0d cycles, required 1",
                     cmd_ready, i);
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((q_pin.size() != 0 || q_rsp.size() != 0) && i < budget) begin
            @(negedge CLK);
            i++;
        end
        n_checks++;
        if (q_pin.size() != 0 || q_rsp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d periods %0d rsps left, required 0",
                     q_pin.size(), q_rsp.size());
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [4:0] len,
                          input logic [31:0] data);
        wait_ready(2000);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_len = len;
        cmd_data = data;
        push_exp(op, len, data, cyc);
        @(negedge CLK);
        cmd_valid = 1'b0;
        repeat (4) begin
            cmd_data = $urandom;
            @(negedge CLK);
        end
        wait_drain(2000);
    endtask

    task automatic release_and_tlr(input string name);
        int rel;
        RST_N = 1'b1;
        rel = cyc;
        push_exp(2'b10, 5'd0, 32'd0, -1);
        while (cmd_ready !== 1'b1 && cyc - rel < 300) @(negedge CLK);
        n_checks++;
        if (cmd_ready !== 1'b1 || cyc - rel != 6 * 2 * DIV + 1) begin
            n_fail++;
            $display("FAIL %s_ready: ready=%b at cycle %0d, required 1 at %0d",
                     name, cmd_ready, cyc - rel, 6 * 2 * DIV + 1);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: got %b, required 0", name, busy);
        end
        wait_drain(100);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks += 7;
        if (JB_TCK !== 1'b0) begin n_fail++; $display("FAIL rst_tck: got %b, required 0", JB_TCK); end
        if (JB_TMS !== 1'b1) begin n_fail++; $display("FAIL rst_tms: got %b, required 1", JB_TMS); end
        if (JB_TDI !== 1'b0) begin n_fail++; $display("FAIL rst_tdi: got %b, required 0", JB_TDI); end
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", cmd_ready); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b, required 1", busy); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
        if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_data: got %h, required 0", rsp_data); end
        release_and_tlr("auto_tlr");
    endtask

    task automatic test_tap_reset();
        do_cmd(2'b10, 5'd7, 32'hFFFF_FFFF);
        do_cmd(2'b11, 5'd3, 32'h0000_0005);
    endtask

    task automatic test_ir_scan();
        do_cmd(2'b01, 5'd3, 32'h0000_0001);
    endtask

    task automatic test_dr_scan();
        do_cmd(2'b00, 5'd8, 32'h0000_0169);
    endtask

    task automatic test_bypass();
        do_cmd(2'b01, 5'd3, 32'h0000_000F);
        do_cmd(2'b00, 5'd7, 32'h0000_00A5);
        n_checks++;
        if (rsp_data !== 32'h0000_004A) begin
            n_fail++;
            $display("FAIL bypass_hold: got %h, required 0000004a", rsp_data);
        end
    endtask

    task automatic test_len_bounds();
        do_cmd(2'b00, 5'd0, 32'h0000_0001);
        do_cmd(2'b00, 5'd31, 32'hDEAD_BEEF);
        do_cmd(2'b01, 5'd31, 32'h8000_0001);
    endtask

    task automatic test_back_to_back();
        int i;
        wait_ready(2000);
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_len = 5'd3;
        cmd_data = 32'h0000_000A;
        push_exp(2'b01, 5'd3, 32'h0000_000A, cyc);
        i = 0;
        @(negedge CLK);
        while (rsp_valid !== 1'b1 && i < 500) begin
            cmd_data = $urandom;
            cmd_op = 2'($urandom);
            cmd_len = 5'($urandom);
            @(negedge CLK);
            i++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: rsp_valid=%b ready=%b, required 1 0",
                     rsp_valid, cmd_ready);
        end
        cmd_op = 2'b00;
        cmd_len = 5'd4;
        cmd_data = 32'h0000_0013;
        @(negedge CLK);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b, required 1", cmd_ready);
        end
        push_exp(2'b00, 5'd4, 32'h0000_0013, cyc);
        @(negedge CLK);
        cmd_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b, required 1", busy);
        end
        wait_drain(2000);
    endtask

    task automatic test_mid_reset();
        int acc;
        wait_ready(2000);
        cmd_valid = 1'b1;
        cmd_op = 2'b00;
        cmd_len = 5'd8;
        cmd_data = 32'h0000_0169;
        acc = cyc;
        push_exp(2'b00, 5'd8, 32'h0000_0169, acc);
        @(negedge CLK);
        cmd_valid = 1'b0;
        while (cyc < acc + 8 * 2 * DIV + 3) @(negedge CLK);
        RST_N = 1'b0;
        q_pin.delete();
        q_rsp.delete();
        q_lat.delete();
        @(negedge CLK);
        n_checks += 4;
        if (JB_TCK !== 1'b0) begin n_fail++; $display("FAIL mid_tck: got %b, required 0", JB_TCK); end
        if (JB_TMS !== 1'b1) begin n_fail++; $display("FAIL mid_tms: got %b, required 1", JB_TMS); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b, required 0", rsp_valid); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", busy); end
        repeat (2) @(negedge CLK);
        release_and_tlr("mid_tlr");
        do_cmd(2'b00, 5'd2, 32'h0000_0005);
    endtask

    initial begin
        test_reset();
        test_tap_reset();
        test_ir_scan();
        test_dr_scan();
        test_bypass();
        test_len_bounds();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_shift_master.md
# jtag_shift_master

On-board JTAG master that generates the TCK/TMS/TDI pin sequences consumed by `OnboardTop` (`JB_TCK`, `JB_TMS`, `JB_TDI`) and samples `JB_TDO`.

- Accepts IR-scan, DR-scan and TAP-reset commands over a valid/ready interface.
- Walks the target TAP from Run-Test/Idle through the scan and back to Run-Test/Idle.
- Returns the captured TDO bits as a response.
- Sits directly upstream of the TAP controller and BSR, replacing hand-driven bench or pin stimulus.

## Interface
- `DIV`, default 5: TCK half-period in CLK cycles; legal range 3..255.
- `CLK` in 1: system clock; all logic on rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block is idle and accepts a command.
- `cmd_op` in 2: 00 = DR scan, 01 = IR scan, 10 = TAP reset, 11 = treated as TAP reset.
- `cmd_len` in 5: scan length minus 1 (1..32 bits); ignored for TAP reset.
- `cmd_data` in 32: TDI bits; LSB is shifted first.
- `rsp_valid` out 1: one-cycle pulse when the command completes.
- `rsp_data` out 32: TDO bits; bit i is sampled during shift bit i; bits ≥ N are zero; zero for TAP reset.
- `busy` out 1: high while a sequence is running, including the post-reset auto-TLR.
- `JB_TCK` out 1: JTAG clock.
- `JB_TMS` out 1: JTAG mode select.
- `JB_TDI` out 1: JTAG data in.
- `JB_TDO` in 1: JTAG data out; asynchronous, so passed through a 2-flop synchroniser inside the block.

## Operation
- **States:** AUTO_TLR, IDLE, RUN, DONE.
- **Handshake:** a command is accepted when `cmd_valid && cmd_ready`. `cmd_ready` = (state == IDLE). Command fields are latched on acceptance.
- **TCK period:** one "period" = 2×DIV CLK cycles, driven by phase counter `ph` running 0..2·DIV−1.
  - At `ph` = 0: TCK driven low; TMS and TDI updated for this period.
  - At `ph` = DIV: TCK driven high; synchronised TDO sampled into `rsp_data[bit]` if this period is a shift period.
- **Period sequences (N = cmd_len+1):**
  - TAP reset: TMS 1,1,1,1,1,0 (6 periods).
  - IR scan: TMS 1,1,0,0, then N shift periods (TMS 0, except 1 on the last), then 1,0. Total N+6 periods.
  - DR scan: TMS 1,0,0, then N shift periods (same TMS rule), then 1,0. Total N+5 periods.
- **TDI:** equals `cmd_data[k]` in shift period k; 0 in all non-shift periods.
- **After reset release:** the block enters AUTO_TLR and runs the TAP-reset sequence. No `rsp_valid` is produced. It then enters IDLE.
- **DONE:** lasts one cycle, asserts `rsp_valid`, and returns to IDLE. `rsp_data` holds its value until the next command completes.
- **Reset mid-operation:** the sequence is abandoned immediately. Outputs go to reset values and AUTO_TLR reruns, so the target TAP is resynchronised.
- **Ignored inputs:** `cmd_valid` while busy is ignored; the command is not latched and there is no error.

## Timing
- **Reset values:**
  - `JB_TCK` = 0, `JB_TMS` = 1, `JB_TDI` = 0.
  - `cmd_ready` = 0, `busy` = 1 (AUTO_TLR pending).
  - `rsp_valid` = 0, `rsp_data` = 0.
- **First TCK period:** starts in the cycle after RST_N is sampled high, or in the cycle after command acceptance.
- **Latency:** `rsp_valid` is asserted P×2×DIV+1 cycles after the acceptance cycle, where P = total periods.
  - Example: IR scan, N = 4, DIV = 5 gives 101 cycles.
- **`cmd_ready`:** first high after reset release is 6×2×DIV+1 cycles later; high again in the cycle after `rsp_valid`.
- **TDO sampling:** samples are taken DIV cycles after the falling edge. The synchroniser delay of 2 cycles is below the minimum DIV of 3, so the target's falling-edge TDO is stable when sampled.
- **Pin outputs:** all registered, no combinational path from inputs.

## Test plan
- **Reset / auto-TLR:** hold RST_N low 3 cycles, then release.
  - TMS is 1 for 5 periods, then 0 for 1 period.
  - `cmd_ready` rises at cycle 61 (DIV = 5).
  - No `rsp_valid`.
- **IR scan:** op = 01, len = 3, data = 4'b0001 (SAMPLE/PRELOAD).
  - TMS per period: 1,1,0,0,0,0,0,1,1,0.
  - TDI per shift period: 1,0,0,0.
  - `rsp_valid` 101 cycles after acceptance.
  - With OnboardTop, `rsp_data[3:0]` = IR capture value.
- **DR scan into BSR:** op = 00, len = 8, data = 9'b101101001, after the IR scan.
  - TDI per shift period: 1,0,0,1,0,1,1,0,1.
  - Next IR scan 4'b0011 (INTEST): `top.from_BSR_to_CL` = 5'b10110 and `top.from_CL_to_BSR` = 4'b0110.
- **BYPASS loopback:** IR = 4'b1111, then DR scan len = 7, data = 8'hA5.
  - `rsp_data` = 32'h0000_004A.
- **Busy / back-to-back:** hold `cmd_valid` high with two different commands queued by the bench.
  - Second command is accepted only in the cycle after the first `rsp_valid`.
  - Changing `cmd_data` while busy has no effect on TDI.
- **Reset mid-scan:** assert RST_N during shift bit 5 of a 9-bit DR scan.
  - Next cycle: TCK = 0, TMS = 1, no `rsp_valid`.
  - After release: a full 6-period TLR sequence is observed.
